// File: rtl/pwm_output_stage.sv
// PWM output stage: prescaler, 8-bit period counter (0..254) and registered 16-bit output mux.
// Define PWM_SHADOW_EN to latch the duty cycle only at the period wrap (glitch-free periods).
module pwm_output_stage #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int unsigned PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
    localparam logic [7:0] CNT_LAST = 8'd254;

    logic [PS_W-1:0] r_prescaler;
    logic [7:0]      r_pwm_cnt;
    logic [15:0]     r_out;
    logic            r_period_start;

    logic            w_tick;
    logic            w_wrap;
    logic [7:0]      w_duty_act;
    logic            w_pwm_sig;
    logic [15:0]     w_en_out;
    logic [15:0]     w_en_pwm;
    logic [15:0]     w_out_next;

    assign w_tick = (r_prescaler == PS_LAST);
    assign w_wrap = w_tick && (r_pwm_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler <= '0;
        end else if (w_tick) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else if (w_wrap) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [7:0] r_duty_act;

    // The duty value present on the wrap edge governs the whole next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_act <= '0;
        end else if (w_wrap) begin
            r_duty_act <= pwm_duty_cycle;
        end
    end

    assign w_duty_act = r_duty_act;
`else
    assign w_duty_act = pwm_duty_cycle;
`endif

    // Count never reaches 255, so duty 0xFF stays high straight through the wrap.
    assign w_pwm_sig  = (r_pwm_cnt < w_duty_act);
    assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_out_next = w_en_out & (~w_en_pwm | {16{w_pwm_sig}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_out_next;
            r_period_start <= w_wrap;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Scoreboard bench for pwm_output_stage: two instances (CLK_DIV=13 and CLK_DIV=1) share stimulus;
// expected outputs come from a cycle-count model of the spec. Build with PWM_SHADOW_EN to test shadowing.
module tb_pwm_output_stage;

    localparam int CD0 = 13;
    localparam int CD1 = 1;
    localparam int P0  = CD0 * 255;
    localparam int P1  = CD1 * 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_out_lo = '0, en_out_hi = '0, en_pwm_lo = '0, en_pwm_hi = '0, duty = '0;
    logic [15:0] out0, out1;
    logic        ps0, ps1;

    pwm_output_stage #(.CLK_DIV(CD0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
        .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
        .pwm_duty_cycle(duty), .out(out0), .period_start(ps0)
    );

    pwm_output_stage #(.CLK_DIV(CD1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
        .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
        .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] out0;
        logic        ps0;
        logic [15:0] out1;
        logic        ps1;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int unsigned k      = 0;      // edges since reset release
    logic [7:0]  sh0    = '0;     // model of the shadowed duty, per instance
    logic [7:0]  sh1    = '0;
    int          hi_cnt[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output after the edge that ends cycle kk: counter value derived from elapsed cycles.
    function automatic logic [15:0] model_out(input int cd, input int unsigned kk, input logic [7:0] d,
                                              input logic [15:0] eo, input logic [15:0] ep);
        int unsigned cnt;
        logic        p;
        cnt = (kk / cd) % 255;
        p   = (cnt < {24'd0, d});
        return eo & (~ep | {16{p}});
    endfunction

    task automatic step();
        exp_t        e;
        logic [7:0]  d0, d1;
        logic [15:0] eo, ep;
        eo = {en_out_hi, en_out_lo};
        ep = {en_pwm_hi, en_pwm_lo};
`ifdef PWM_SHADOW_EN
        d0 = sh0;
        d1 = sh1;
`else
        d0 = duty;
        d1 = duty;
`endif
        e.out0 = model_out(CD0, k, d0, eo, ep);
        e.ps0  = ((k + 1) % P0) == 0;
        e.out1 = model_out(CD1, k, d1, eo, ep);
        e.ps1  = ((k + 1) % P1) == 0;
        sb_q.push_back(e);
        if (e.ps0) sh0 = duty;
        if (e.ps1) sh1 = duty;
        k++;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("out_div13", {16'd0, out0}, {16'd0, e.out0});
        check("ps_div13", {31'd0, ps0}, {31'd0, e.ps0});
        check("out_div1", {16'd0, out1}, {16'd0, e.out1});
        check("ps_div1", {31'd0, ps1}, {31'd0, e.ps1});
    endtask

    task automatic wait_ps(input int which, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((which == 0) ? ps0 : ps1) !== 1'b1 && n < limit);
        if (((which == 0) ? ps0 : ps1) !== 1'b1)
            check("period_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_cycles(input int which, input int ncyc);
        for (int b = 0; b < 16; b++) hi_cnt[b] = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            for (int b = 0; b < 16; b++)
                hi_cnt[b] += int'((which == 0) ? out0[b] : out1[b]);
        end
    endtask

    task automatic set_masks(input logic [15:0] eo, input logic [15:0] ep);
        {en_out_hi, en_out_lo} = eo;
        {en_pwm_hi, en_pwm_lo} = ep;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sum, hi_a, exp_hi, exp_b;
        logic [15:0] eo6, ep6;

        // Power-on reset state
        #23;
        check("reset_out0", {16'd0, out0}, 32'd0);
        check("reset_ps0", {31'd0, ps0}, 32'd0);
        check("reset_out1", {16'd0, out1}, 32'd0);
        check("reset_ps1", {31'd0, ps1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;

        // T2: static drive, one-clock latency
        for (int i = 0; i < 3; i++) step();
        set_masks(16'hFFFF, 16'h0000);
        step();
        check("t2_static_ffff", {16'd0, out0}, 32'h0000_FFFF);
        set_masks(16'h00F0, 16'h0000);
        step();
        check("t2_static_00f0", {16'd0, out0}, 32'h0000_00F0);

        // T1: random activity, asynchronous reset mid-period, restart timing
        for (int i = 0; i < 700; i++) begin
            set_masks(16'($urandom), 16'($urandom));
            duty = 8'($urandom);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_out0", {16'd0, out0}, 32'd0);
        check("t1_async_ps0", {31'd0, ps0}, 32'd0);
        check("t1_async_out1", {16'd0, out1}, 32'd0);
        check("t1_async_ps1", {31'd0, ps1}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k   = 0;
        sh0 = '0;
        sh1 = '0;
        wait_ps(0, P0 + 10, n);
        check("t1_first_period_start", n, P0);

        // T3: 50% duty on bit 0
        set_masks(16'h0001, 16'h0001);
        duty = 8'h80;
        wait_ps(0, P0 + 10, n);
        count_cycles(0, P0);
        check("t3_high_cycles", hi_cnt[0], 32'd1664);
        check("t3_low_cycles", P0 - hi_cnt[0], 32'd1651);
        sum = 0;
        for (int b = 1; b < 16; b++) sum += hi_cnt[b];
        check("t3_other_bits", sum, 32'd0);

        // T4: duty extremes across three periods
        duty = 8'h00;
        wait_ps(0, P0 + 10, n);
        count_cycles(0, 3 * P0);
        check("t4_duty00_high", hi_cnt[0], 32'd0);
        duty = 8'hFF;
        wait_ps(0, P0 + 10, n);
        count_cycles(0, 3 * P0);
        check("t4_dutyff_low", 3 * P0 - hi_cnt[0], 32'd0);

        // T5: duty 0x40 -> 0xC0 at count 100
        duty = 8'h40;
        wait_ps(0, P0 + 10, n);
        hi_a = 0;
        for (int j = 0; j < P0; j++) begin
            if (j == 100 * CD0) duty = 8'hC0;
            step();
            hi_a += int'(out0[0]);
`ifndef PWM_SHADOW_EN
            if (j == 100 * CD0) check("t5_rise_1clk", {31'd0, out0[0]}, 32'd1);
`endif
        end
`ifdef PWM_SHADOW_EN
        exp_hi = 64 * CD0;
`else
        exp_hi = 64 * CD0 + 92 * CD0;
`endif
        check("t5_change_period", hi_a, exp_hi);
        count_cycles(0, P0);
        check("t5_next_period", hi_cnt[0], 32'd2496);

        // T6: mixed masks on the CLK_DIV=1 instance
        eo6 = 16'hA5A5;
        ep6 = 16'h0F0F;
        set_masks(eo6, ep6);
        duty = 8'h20;
        wait_ps(1, P1 + 10, n);
        count_cycles(1, P1);
        for (int b = 0; b < 16; b++) begin
            exp_b = eo6[b] ? (ep6[b] ? 32 : 255) : 0;
            check($sformatf("t6_bit%0d", b), hi_cnt[b], exp_b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
